ram_bus_master: RTL and testbench
=================================

# ram_bus_master

Clocked initiator for the subleq machine's asynchronous 256×8 RAM bus. It accepts single-word read/write requests from the CPU core over a valid/ready handshake. It sequences the active-low strobes (ope, ctl, ena), the address and the bidirectional data bus with guaranteed setup, hold and turnaround. Read data returns to the core on a one-cycle response strobe.

## Interface
- ADDR_W, 8, address width (RAM depth 2^ADDR_W)
- DATA_W, 8, data width
- RD_WAIT, 1, cycles ope is held low before read data is sampled (≥1)
- WR_PULSE, 1, cycles ctl is held low per write (≥1)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_adr  in  ADDR_W  request address
- req_wdat  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse: rsp_rdat holds new read data
- rsp_rdat  out  DATA_W  last read data, held until the next read completes
- ope  out  1  RAM output enable, 0 = enabled
- ctl  out  1  RAM control, 0 = write, 1 = read; the RAM captures data on ctl falling
- ena  out  1  RAM chip enable, 0 = enabled
- adr  out  ADDR_W  RAM address
- dat  inout  DATA_W  RAM data bus; driven by this block only in write states, Z otherwise

## Operation
- All RAM-side outputs and dat_oe are registered and decoded from the state register; there are no combinational paths from req_* to the bus.
- Handshake: transfer occurs when req_valid & req_ready at a posedge. The block latches req_we, req_adr and req_wdat at that edge. Core inputs are ignored in all other cycles.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_WAIT, TURN.
- IDLE: ope=ctl=ena=1, dat Z, req_ready=1. On handshake, go to W_SETUP if we=1, otherwise go to R_ADDR.
- W_SETUP (1 cycle): ena=0, ctl=1, ope=1, adr and dat driven.
- W_PULSE (WR_PULSE cycles): ctl=0; the falling edge of ctl commits the write in the RAM.
- W_HOLD (1 cycle): ctl=1, ena=0, dat still driven. Then return to IDLE.
- R_ADDR (1 cycle): ena=0, ctl=1, ope=1, adr driven, dat Z.
- R_WAIT (RD_WAIT cycles): ope=0. dat is sampled into rsp_rdat at the final R_WAIT edge.
- TURN (1 cycle): ope=ctl=ena=1, rsp_valid=1, neither side drives. Then return to IDLE.
- Invariants:
  - Never drive dat while ope=0.
  - ctl falls only while ena=0 and dat is stable, and falls exactly once per write.
  - ctl is never 0 in read states.
  - adr is stable from SETUP/ADDR through HOLD/WAIT.
- Writes produce no response; rsp_valid pulses only for reads.
- Wait counter width is $clog2(max(RD_WAIT, WR_PULSE)+1). The counter loads on state entry and counts down to 0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdat=0, ope=ctl=ena=1, adr=0, dat Z, state IDLE.
- Cycle numbering: cycle k is the k-th cycle after the handshake edge.
- Write: W_SETUP is cycle 1. ctl is low for cycles 2..1+WR_PULSE. W_HOLD is cycle 2+WR_PULSE. req_ready=1 at cycle 3+WR_PULSE; with defaults that is 4 cycles between accepted writes.
- Read: R_ADDR is cycle 1. ope is low for cycles 2..1+RD_WAIT. rsp_valid and the new rsp_rdat appear at cycle 2+RD_WAIT (TURN). req_ready=1 at cycle 3+RD_WAIT.
- Turnaround:
  - TURN guarantees one undriven cycle after every read.
  - After a write, the cycle between the W_HOLD→IDLE edge and the next SETUP/ADDR has ena=1.
  - No back-to-back overlap is possible.
- Reset mid-operation takes effect at the next edge:
  - All strobes go high, dat is released, any pending rsp_valid is suppressed, and rsp_rdat is cleared.
  - A write whose ctl has already fallen is treated as committed.
  - A read interrupted before TURN returns nothing.
- req_valid held high in IDLE is accepted immediately. The core must hold its request stable while req_ready=0; this block does not depend on it.

## Structure
- Package subleq_mem_pkg:
  - state encoding constants
  - active-low strobe constants STB_ON=0, STB_OFF=1
  - ADDR_W/DATA_W defaults shared with the RAM and the CPU core
- One sub-module bus_tristate (DATA_W): dat_o, dat_oe → inout dat, dat_i. It isolates the only Z-driver.
- The top-level block contains the FSM, wait counter, request latch and response register.

## Test plan
- Reset, with the behavioural RAM model attached: assert rst for 2 cycles → ope=ctl=ena=1, dat=Z, req_ready=1, rsp_rdat=0.
- Write 0x5A to adr 0x10 (defaults) → exactly one ctl fall, with ena=0 and dat=0x5A. The model's mem[0x10]=0x5A. req_ready returns at cycle 4.
- Read adr 0x00 with mem[0]=5 → rsp_valid high for exactly one cycle at cycle 3, rsp_rdat=5. dat is never driven by this block while ope=0.
- Write 0xC3 to 0x20, then immediately read 0x20 → rsp_rdat=0xC3. A contention checker flags no cycle where both sides drive dat.
- Assert rst during R_WAIT (RD_WAIT=3) → next cycle ope=1, no rsp_valid. A following read of 0x03 returns 8.
- req_valid held high with four alternating read/write requests → each is accepted only in IDLE. Strobes match the per-state table above, and the ctl fall count equals the write count (2).

Source files
------------

// File: rtl/subleq_mem_pkg.sv
// Shared definitions for the subleq machine's RAM bus.
// Holds the bus master state encoding, the active-low strobe levels, the
// default address/data widths shared with the RAM and CPU core, and the
// per-state strobe decode used by the bus master.
package subleq_mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_SETUP = 3'd1,
    S_W_PULSE = 3'd2,
    S_W_HOLD  = 3'd3,
    S_R_ADDR  = 3'd4,
    S_R_WAIT  = 3'd5,
    S_TURN    = 3'd6
  } bus_state_e;

  // Bus-side levels a state presents: {ope, ctl, ena, dat_oe}.
  function automatic logic [3:0] state_strobes(bus_state_e s);
    logic [3:0] r;
    r = {STB_OFF, STB_OFF, STB_OFF, 1'b0};
    case (s)
      S_IDLE:    r = {STB_OFF, STB_OFF, STB_OFF, 1'b0};
      S_W_SETUP: r = {STB_OFF, STB_OFF, STB_ON,  1'b1};
      S_W_PULSE: r = {STB_OFF, STB_ON,  STB_ON,  1'b1};
      S_W_HOLD:  r = {STB_OFF, STB_OFF, STB_ON,  1'b1};
      S_R_ADDR:  r = {STB_OFF, STB_OFF, STB_ON,  1'b0};
      S_R_WAIT:  r = {STB_ON,  STB_OFF, STB_ON,  1'b0};
      S_TURN:    r = {STB_OFF, STB_OFF, STB_OFF, 1'b0};
      default:   r = {STB_OFF, STB_OFF, STB_OFF, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_tristate.sv
// Tristate pad for the RAM data bus; the only place that drives Z.
// Ports: dat_o (value to drive), dat_oe (1 = drive), dat (bidirectional
// bus), dat_i (bus value as seen by the block).
module bus_tristate #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] dat_o,
  input  logic              dat_oe,
  inout  wire  [DATA_W-1:0] dat,
  output logic [DATA_W-1:0] dat_i
);

  assign dat   = dat_oe ? dat_o : {DATA_W{1'bz}};
  assign dat_i = dat;

endmodule

// File: rtl/ram_bus_master.sv
// Clocked initiator for the asynchronous 256x8 RAM bus.
// Core side: req_valid/req_ready handshake with req_we, req_adr, req_wdat;
// read data returns on rsp_rdat with a one-cycle rsp_valid pulse.
// RAM side: active-low ope/ctl/ena, adr, and bidirectional dat. Every
// RAM-side output is a register loaded with the decode of the next state,
// so nothing on the bus depends combinationally on req_*.
module ram_bus_master
  import subleq_mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdat,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdat,
  output logic              ope,
  output logic              ctl,
  output logic              ena,
  output logic [ADDR_W-1:0] adr,
  inout  wire  [DATA_W-1:0] dat
);

  localparam int MAXW  = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CNT_W = $clog2(MAXW + 1);

  bus_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ope_q, ctl_q, ena_q, dat_oe_q;
  logic              ready_q, rsp_valid_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdat_q, rdat_q;
  logic [DATA_W-1:0] dat_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                        <= S_IDLE;
      {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_IDLE);
      ready_q                        <= 1'b1;
      rsp_valid_q                    <= 1'b0;
      rdat_q                         <= '0;
      adr_q                          <= '0;
      wdat_q                         <= '0;
      cnt_q                          <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid && ready_q) begin
          adr_q   <= req_adr;
          wdat_q  <= req_wdat;
          ready_q <= 1'b0;
          if (req_we) begin
            state_q                        <= S_W_SETUP;
            {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_W_SETUP);
          end else begin
            state_q                        <= S_R_ADDR;
            {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_R_ADDR);
          end
        end
        S_W_SETUP: begin
          state_q                        <= S_W_PULSE;
          {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_W_PULSE);
          cnt_q                          <= CNT_W'(WR_PULSE - 1);
        end
        S_W_PULSE: begin
          if (cnt_q == '0) begin
            state_q                        <= S_W_HOLD;
            {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_W_HOLD);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_W_HOLD: begin
          state_q                        <= S_IDLE;
          {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_IDLE);
          ready_q                        <= 1'b1;
        end
        S_R_ADDR: begin
          state_q                        <= S_R_WAIT;
          {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_R_WAIT);
          cnt_q                          <= CNT_W'(RD_WAIT - 1);
        end
        S_R_WAIT: begin
          // Sample on the last edge ope is still low, then release the bus.
          if (cnt_q == '0) begin
            state_q                        <= S_TURN;
            {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_TURN);
            rdat_q                         <= dat_i;
            rsp_valid_q                    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_TURN: begin
          state_q                        <= S_IDLE;
          {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_IDLE);
          ready_q                        <= 1'b1;
        end
        default: begin
          state_q                        <= S_IDLE;
          {ope_q, ctl_q, ena_q, dat_oe_q} <= state_strobes(S_IDLE);
          ready_q                        <= 1'b1;
        end
      endcase
    end
  end

  bus_tristate #(.DATA_W(DATA_W)) u_tri (
    .dat_o  (wdat_q),
    .dat_oe (dat_oe_q),
    .dat    (dat),
    .dat_i  (dat_i)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdat  = rdat_q;
  assign ope       = ope_q;
  assign ctl       = ctl_q;
  assign ena       = ena_q;
  assign adr       = adr_q;

endmodule

// File: tb/tb_ram_bus_master.sv
module tb_ram_bus_master;

  localparam int RD = 3;
  localparam int WP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [7:0] req_adr = '0, req_wdat = '0;
  logic       req_ready, rsp_valid, ope, ctl, ena;
  logic [7:0] rsp_rdat, adr;
  wire  [7:0] dat;

  int vectors = 0, miscompares = 0, falls = 0;
  logic ram_live = 1'b0;
  logic [7:0] ram  [256];   // RAM attached to the bus
  logic [7:0] refm [256];   // expected contents
  logic ram_drive;

  ram_bus_master #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(RD), .WR_PULSE(WP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_adr(req_adr), .req_wdat(req_wdat),
    .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat),
    .ope(ope), .ctl(ctl), .ena(ena), .adr(adr), .dat(dat)
  );

  always #5 clk = ~clk;

  // Asynchronous RAM: drives on ope low, captures on ctl falling.
  assign ram_drive = ram_live && !ope && !ena && ctl;
  assign dat = ram_drive ? ram[adr] : 8'bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge ctl) if (ram_live) begin
    falls++;
    chk("ctl_fall_ena", {31'd0, ena}, 32'd0);
    if (!ena) ram[adr] <= dat;
  end

  always @(negedge clk) if (ram_live && !rst)
    chk("bus_contention", {30'd0, dut.dat_oe_q & ram_drive, dut.dat_oe_q & ~ope}, 32'd0);

  // One transaction checked cycle by cycle against the timing rules.
  task automatic do_op(input logic we, input logic [7:0] a, input logic [7:0] d, input bit hold);
    int n, f0, last;
    logic e_ope, e_ctl, e_ena, e_rdy, e_rv;
    req_we = we; req_adr = a; req_wdat = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    f0 = falls;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    last = we ? 2 + WP : 2 + RD;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      e_ope = !(!we && k >= 2 && k <= 1 + RD);
      e_ctl = !(we && k >= 2 && k <= 1 + WP);
      e_ena = !(k <= (we ? 2 + WP : 1 + RD));
      e_rdy = (k == last + 1);
      e_rv  = (!we && k == last);
      chk(we ? "wr_strobes" : "rd_strobes", {27'd0, ope, ctl, ena, req_ready, rsp_valid},
          {27'd0, e_ope, e_ctl, e_ena, e_rdy, e_rv});
      if (k <= (we ? last : last - 1)) chk("adr", {24'd0, adr}, {24'd0, a});
      if (we && k <= last) chk("wdat_bus", {24'd0, dat}, {24'd0, d});
      if (!we && k == last) chk("rdat", {24'd0, rsp_rdat}, {24'd0, refm[a]});
    end
    if (we) begin
      refm[a] = d;
      chk("ram_cell", {24'd0, ram[a]}, {24'd0, d});
    end
    chk("ctl_falls", falls - f0, we ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      refm[i] = ram[i];
    end
    ram[0] = 8'd5;  refm[0] = 8'd5;
    ram[3] = 8'd8;  refm[3] = 8'd8;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {28'd0, ope, ctl, ena, req_ready}, 32'hF);
    chk("rst_outs", {23'd0, rsp_valid, rsp_rdat}, 32'd0);
    chk("rst_dat_oe", {31'd0, dut.dat_oe_q}, 32'd0);
    rst = 1'b0;
    ram_live = 1'b1;
    @(negedge clk);

    // Directed write, read, write-then-read
    do_op(1'b1, 8'h10, 8'h5A, 1'b0);
    do_op(1'b0, 8'h00, 8'h00, 1'b0);
    do_op(1'b1, 8'h20, 8'hC3, 1'b0);
    do_op(1'b0, 8'h20, 8'h00, 1'b0);

    // Reset in the middle of R_WAIT
    req_we = 1'b0; req_adr = 8'h07; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);                       // cycle 1: R_ADDR
    @(negedge clk);                       // cycle 2: R_WAIT
    chk("rwait_ope", {31'd0, ope}, 32'd0);
    @(negedge clk);                       // cycle 3: R_WAIT
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", {27'd0, ope, ctl, ena, req_ready, rsp_valid}, 32'h1E);
    chk("midrst_rdat", {24'd0, rsp_rdat}, 32'd0);
    chk("midrst_dat_oe", {31'd0, dut.dat_oe_q}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_op(1'b0, 8'h03, 8'h00, 1'b0);

    // req_valid held high across alternating read/write requests
    do_op(1'b0, 8'h10, 8'h00, 1'b1);
    do_op(1'b1, 8'h11, 8'h77, 1'b1);
    do_op(1'b0, 8'h11, 8'h00, 1'b1);
    do_op(1'b1, 8'h12, 8'h99, 1'b0);

    // Random traffic over a small address window so reads hit earlier writes
    for (int i = 0; i < 24; i++)
      do_op(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
            (i != 23) && 1'($urandom));
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", {28'd0, ope, ctl, ena, req_ready}, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
